// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Registered, parameterised up/down counter.
// - The primary output is the count in Gray code.
// - A binary shadow of the same count is also output.
// - A Gray-coded load value is converted to binary internally.
// - Both outputs come from flops and change in the same cycle.
//
// Optional feature macro: GRAY_CNT_TC_EN
//   When defined, the terminal-count pulse output `tc` and its flop exist.
//   When undefined, `tc` is absent from the port list.
//
// Parameters
//   WIDTH      counter width in bits (legal range 2..16)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   en         count enable; one step per cycle while high
//   up_dn      direction: 1 = increment, 0 = decrement
//   load       synchronous load strobe (overrides en)
//   load_gray  Gray-coded value to load
//   gray       registered Gray-code count
//   bin        registered binary equivalent of gray
//   tc         one-cycle pulse on the cycle the outputs first show a wrapped
//              value (GRAY_CNT_TC_EN only)
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
`ifdef GRAY_CNT_TC_EN
  output logic [WIDTH-1:0] bin,
  output logic             tc
`else
  output logic [WIDTH-1:0] bin
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: the MSB passes through; each lower bit is the running
  // XOR of all Gray bits above and including it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_next_cnt;
`ifdef GRAY_CNT_TC_EN
  logic             r_tc;
  logic             w_wrap;
`endif

  // Next-count selection with priority load > en > hold.
  always_comb begin
    w_next_cnt = r_cnt;
    if (load) begin
      w_next_cnt = gray2bin(load_gray);
    end else if (en) begin
      if (up_dn) begin
        w_next_cnt = r_cnt + ONE;
      end else begin
        w_next_cnt = r_cnt - ONE;
      end
    end else begin
      w_next_cnt = r_cnt;
    end
  end

`ifdef GRAY_CNT_TC_EN
  // Wrap detection: only a counting step can wrap; a load never flags tc.
  always_comb begin
    w_wrap = 1'b0;
    if (load) begin
      w_wrap = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        w_wrap = (r_cnt == ALL_ONES);
      end else begin
        w_wrap = (r_cnt == ZERO);
      end
    end else begin
      w_wrap = 1'b0;
    end
  end
`endif

  // Count, Gray and terminal-count registers. The Gray flop is loaded from
  // the next binary count so it is never a decode of the count flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= ZERO;
      r_gray <= ZERO;
`ifdef GRAY_CNT_TC_EN
      r_tc   <= 1'b0;
`endif
    end else begin
      r_cnt  <= w_next_cnt;
      r_gray <= bin2gray(w_next_cnt);
`ifdef GRAY_CNT_TC_EN
      r_tc   <= w_wrap;
`endif
    end
  end

  assign gray = r_gray;
  assign bin  = r_cnt;
`ifdef GRAY_CNT_TC_EN
  assign tc   = r_tc;
`endif

endmodule
